alu_share_arbiter: RTL and testbench

- Shares one ALU instance between NUM_REQ requesters using per-requester valid/ready handshakes and round-robin arbitration.
- Latches the winning operands and opcode, runs one ALU evaluation, and returns a registered result, zero flag and requester ID over a single response channel with backpressure.
- Sits between the execute-stage issue logic and the ALU.

---
 rtl/alu_share_arbiter_pkg.sv | 17 +
 rtl/alu_share_arbiter_alu.sv | 25 ++
 rtl/alu_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the shared-ALU arbiter slice.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MAX = 3'b100;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// 32-bit ALU: AND/OR/ADD/SUB/unsigned SLT; undefined opcodes yield 0.
module alu
    import alu_share_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_control,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        case (alu_control)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {31'b0, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters with a
// backpressured, registered response channel.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic                 busy
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;

    logic [31:0]     alu_result;
    logic            alu_zero;
    logic            win_found;
    logic [ID_W-1:0] win_id;

    // Search upward from rr_ptr, wrapping at NUM_REQ (not necessarily a power of two).
    always_comb begin
        int unsigned idx;
        logic [NUM_REQ-1:0] shifted;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        shifted   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            shifted = req_valid >> idx;
            if (!win_found && shifted[0]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign req_ready = (rst_n && state_q == IDLE && win_found) ?
                       (NUM_REQ'(1) << win_id) : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = rsp_valid_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    a_d      = 32'(req_a >> (32 * win_id));
                    b_d      = 32'(req_b >> (32 * win_id));
                    op_d     = 3'(req_op >> (3 * win_id));
                    id_d     = win_id;
                    rr_ptr_d = (32'(win_id) == NUM_REQ - 1) ? '0 : ID_W'(32'(win_id) + 1);
                    busy_d   = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_err_d    = (op_q > OP_MAX);
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    alu u_alu (
        .a           (a_q),
        .b           (b_q),
        .alu_control (op_q),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter with three requesters
// and a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a, req_b;
    logic [N*3-1:0]  req_op;
    logic            rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_zero, rsp_err, busy;

    int checks = 0;
    int errors = 0;
    int last_g;
    logic [31:0] ta [N];
    logic [31:0] tbv[N];
    logic [2:0]  to [N];

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next grant: first valid requester after the previously granted one.
    function automatic int pick_ref(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive_ops();
        logic [N*32-1:0] pa, pb;
        logic [N*3-1:0]  po;
        pa = '0; pb = '0; po = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pa = (pa << 32) | (N*32)'(ta[i]);
            pb = (pb << 32) | (N*32)'(tbv[i]);
            po = (po << 3)  | (N*3)'(to[i]);
        end
        req_a = pa; req_b = pb; req_op = po;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        ta[i] = a; tbv[i] = b; to[i] = op;
    endtask

    // Entered and left at posedge+1ns with the DUT idle.
    task automatic transact(input logic [N-1:0] v, input int hold);
        int w;
        logic [31:0] er;
        logic ez, ee;
        req_valid = v;
        drive_ops();
        rsp_ready = 1'b0;
        #1;
        w  = pick_ref(v, last_g);
        er = alu_ref(ta[w], tbv[w], to[w]);
        ez = (er == 32'd0);
        ee = (to[w] > 3'd4);
        chk("grant", req_ready, N'(1) << w);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        last_g = w;
        for (int i = 0; i < N; i++) begin
            ta[i] = $urandom; tbv[i] = $urandom; to[i] = 3'($urandom);
        end
        drive_ops();
        chk("exec_ready", req_ready, 0);
        chk("exec_busy", busy, 1);
        chk("exec_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, w);
        chk("rsp_result", rsp_result, er);
        chk("rsp_zero", rsp_zero, ez);
        chk("rsp_err", rsp_err, ee);
        chk("resp_ready", req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, w);
            chk("hold_result", rsp_result, er);
            chk("hold_zero", rsp_zero, ez);
            chk("hold_err", rsp_err, ee);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'd0, 32'd0, 3'd0);
        drive_ops();
        #23 rst_n = 1'b1;
        last_g = N - 1;

        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            chk("rst_busy", busy, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", rsp_valid, 0);
            @(posedge clk); #1;
        end

        set_req(1, 32'd7, 32'd5, 3'b011);
        transact(3'b010, 0);

        for (int r = 0; r < 4; r++) begin
            set_req(0, 32'd1, 32'd1, 3'b010);
            set_req(1, 32'hF0, 32'h0F, 3'b000);
            transact(3'b011, 0);
        end

        set_req(2, 32'd3, 32'd9, 3'b100);
        transact(3'b100, 5);

        set_req(0, 32'd3, 32'd3, 3'b110);
        transact(3'b001, 0);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b010);
        transact(3'b010, 0);

        // Grant req0 (pointer moves to 1), reset in EXEC, then all valid must grant req0.
        set_req(0, 32'd10, 32'd20, 3'b010);
        drive_ops();
        req_valid = 3'b001;
        #1;
        @(posedge clk); #1;
        req_valid = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_result", rsp_result, 0);
        chk("mid_rst_id", rsp_id, 0);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        last_g = N - 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) set_req(i, 32'(i + r), 32'd2, 3'b011);
            transact(3'b111, 0);
        end

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: ta[i] = 32'hFFFF_FFFF;
                    1: ta[i] = 32'(int'($urandom_range(0, 4)));
                    default: ta[i] = $urandom;
                endcase
                tbv[i] = ($urandom_range(0, 3) == 0) ? ta[i] : $urandom;
                to[i]  = 3'($urandom_range(0, 7));
            end
            transact(N'($urandom_range(1, 7)), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
